// File: rtl/dmem_responder_pkg.sv
// Shared constants for the data-memory responder and the memory-access stage:
// funct3 access widths, responder state encoding and default store depth.
package dmem_responder_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  localparam int unsigned DMEM_DEPTH_WORDS = 1024;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for stores and little-endian extraction/extension for loads.
// Also flags misaligned accesses and illegal width encodings.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [2:0]  width,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wword,
  output logic [31:0] load_data,
  output logic        align_err
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val  = mem_word[8*offset +: 8];
    half_val  = offset[1] ? mem_word[31:16] : mem_word[15:0];
    byte_en   = 4'b0000;
    wword     = '0;
    load_data = '0;
    align_err = 1'b0;
    case (width)
      MEM_B, MEM_BU: begin
        byte_en   = 4'b0001 << offset;
        wword     = {4{wdata[7:0]}};
        load_data = (width == MEM_B) ? {{24{byte_val[7]}}, byte_val} : {24'h0, byte_val};
      end
      MEM_H, MEM_HU: begin
        align_err = offset[0];
        byte_en   = offset[1] ? 4'b1100 : 4'b0011;
        wword     = {2{wdata[15:0]}};
        load_data = (width == MEM_H) ? {{16{half_val[15]}}, half_val} : {16'h0, half_val};
      end
      MEM_W: begin
        align_err = (offset != 2'b00);
        byte_en   = 4'b1111;
        wword     = wdata;
        load_data = mem_word;
      end
      default: align_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, performs it after a fixed
// latency and holds the response until the requester consumes it.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_WORDS,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_width,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  LAT_CNT = 4'(LATENCY);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("dmem_responder: LATENCY must be in 1..15");
  end
  if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("dmem_responder: DEPTH_WORDS must be a power of two >= 2");
  end

  dmem_state_e state;
  logic [3:0]  cnt;

  logic        wr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  width_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic             accept;
  logic             access;
  logic             in_range;
  logic             align_err;
  logic             err;
  logic             commit;
  logic [31:0]      word_idx;
  logic [IDX_W-1:0] idx;
  logic [31:0]      mem_word;
  logic [31:0]      wword;
  logic [31:0]      load_data;
  logic [3:0]       byte_en;

  assign req_ready = (state == StIdle) || ((state == StResp) && resp_ready);
  assign accept    = req_valid && req_ready;
  assign access    = (state == StWait) && (cnt == 4'd1);

  assign word_idx  = {2'b00, addr_q[31:2]};
  assign in_range  = word_idx < DEPTH_WORDS;
  assign idx       = addr_q[IDX_W+1:2];
  assign mem_word  = mem[idx];
  assign err       = align_err || !in_range;
  // rst gate covers a reset that lands on the access edge itself.
  assign commit    = access && wr_q && !err && !rst;

  dmem_lane_align u_lane_align (
    .width     (width_q),
    .offset    (addr_q[1:0]),
    .wdata     (wdata_q),
    .mem_word  (mem_word),
    .byte_en   (byte_en),
    .wword     (wword),
    .load_data (load_data),
    .align_err (align_err)
  );

  // Request fields are latched only on acceptance; later input changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      width_q <= MEM_W;
    end else if (accept) begin
      wr_q    <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      width_q <= req_width;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (accept) begin
            state <= StWait;
            cnt   <= LAT_CNT;
          end
        end
        StWait: begin
          cnt <= cnt - 4'd1;
          if (access) begin
            state      <= StResp;
            resp_valid <= 1'b1;
            resp_err   <= err;
            resp_rdata <= (err || wr_q) ? '0 : load_data;
          end
        end
        StResp: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            if (accept) begin
              state <= StWait;
              cnt   <= LAT_CNT;
            end else begin
              state <= StIdle;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Store contents survive reset and are undefined after power-up.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

endmodule
